// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared types, frame states and field constants for the Ethernet
//            frame transmit and receive paths.
// Revision : 1.0  initial release
// ============================================================================
package eth_pkg;

    typedef logic [47:0] mac_addr_t;

    // Frame field sequencing, shared with the receiver.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_PREAMBLE = 4'd2,
        ST_SFD      = 4'd3,
        ST_MACDST   = 4'd4,
        ST_MACSRC   = 4'd5,
        ST_LEN      = 4'd6,
        ST_PAYLOAD  = 4'd7,
        ST_FCS      = 4'd8,
        ST_DONE     = 4'd9
    } frame_state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0] SFD_BYTE      = 8'hAB;
    localparam int         MAC_BYTES     = 6;
    localparam int         LEN_BYTES     = 2;

    // MAC byte selection, least-significant byte first on the wire.
    function automatic logic [7:0] mac_byte(input mac_addr_t mac, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:    b = mac[7:0];
            3'd1:    b = mac[15:8];
            3'd2:    b = mac[23:16];
            3'd3:    b = mac[31:24];
            3'd4:    b = mac[39:32];
            3'd5:    b = mac[47:40];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_frame_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_tx_if
// Purpose  : Request, payload-FIFO and serial-byte signals of the frame
//            transmitter bundled as one interface.
// Revision : 1.0  initial release
// ============================================================================
interface eth_frame_tx_if;
    import eth_pkg::*;

    logic        tx_req;
    mac_addr_t   tx_dst_mac;
    logic [15:0] tx_len;
    logic        tx_ack;
    logic        tx_err;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_rdy;
    logic        peer_ready;
    logic        start;
    logic [7:0]  data;
    logic        busy;
    logic        done;
    logic        underrun;

    // Transmitter side.
    modport slave (
        input  tx_req, tx_dst_mac, tx_len, in_data, in_vld, peer_ready,
        output tx_ack, tx_err, in_rdy, start, data, busy, done, underrun
    );

    // Requester / FIFO / receiver side.
    modport master (
        output tx_req, tx_dst_mac, tx_len, in_data, in_vld, peer_ready,
        input  tx_ack, tx_err, in_rdy, start, data, busy, done, underrun
    );
endinterface
`default_nettype wire

// File: rtl/eth_lrc_acc.sv
`default_nettype none
// ============================================================================
// Module   : eth_lrc_acc
// Purpose  : 8-bit modular byte-sum (LRC) accumulator with two's-complement
//            frame-check byte output.
// Revision : 1.0  initial release
// ============================================================================
module eth_lrc_acc (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_clear,
    input  wire logic       i_en,
    input  wire logic [7:0] i_byte,
    output logic      [7:0] o_sum,
    output logic      [7:0] o_fcs_byte
);

    logic [7:0] r_sum;

    // Running sum; clear has priority so a new frame never inherits old bytes.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sum <= 8'h00;
        end else if (i_en) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_sum      = r_sum;
    assign o_fcs_byte = (~r_sum) + 8'd1;

endmodule
`default_nettype wire

// File: rtl/eth_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_tx
// Purpose  : Serial Ethernet-style frame generator: preamble, SFD, MACs,
//            length, FIFO-sourced payload and repeated LRC check byte.
// Revision : 1.0  initial release
// ============================================================================
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter mac_addr_t   SRC_MAC_ADDR   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] MAX_LEN        = 16'd1500,
    parameter int          PREAMBLE_BYTES = 7,
    parameter int          FCS_BYTES      = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    eth_frame_tx_if.slave bus
);

    localparam logic [15:0] c_PRE_LAST = 16'(PREAMBLE_BYTES - 1);
    localparam logic [15:0] c_MAC_LAST = 16'(MAC_BYTES - 1);
    localparam logic [15:0] c_LEN_LAST = 16'(LEN_BYTES - 1);
    localparam logic [15:0] c_FCS_LAST = 16'(FCS_BYTES - 1);

    frame_state_t r_state, w_state_nxt;
    logic [15:0]  r_cnt, w_cnt_nxt;
    mac_addr_t    r_dst_mac;
    logic [15:0]  r_len;
    logic         r_start, r_busy, r_done, r_underrun, r_tx_err;
    logic [7:0]   r_data, w_data_nxt;
    logic         w_tx_ack, w_len_err, w_in_rdy, w_underrun;
    logic         w_lrc_en;
    logic [7:0]   w_lrc_sum, w_fcs_byte;

    // Field sequencing: next state, field counter, next wire byte, handshakes.
    always_comb begin
        w_tx_ack    = ~rst & bus.tx_req & (r_state == ST_IDLE) & bus.peer_ready
                      & (bus.tx_len <= MAX_LEN);
        w_len_err   = ~rst & bus.tx_req & (r_state == ST_IDLE) & (bus.tx_len > MAX_LEN);
        // in_rdy marks the edge that registers a payload byte onto data.
        w_in_rdy    = ~rst & (((r_state == ST_LEN) && (r_cnt == c_LEN_LAST) && (r_len != 16'd0))
                      || ((r_state == ST_PAYLOAD) && (r_cnt != r_len - 16'd1)));
        w_underrun  = w_in_rdy & ~bus.in_vld;
        w_state_nxt = r_state;

        case (r_state)
            ST_IDLE:     if (w_tx_ack) w_state_nxt = ST_START;
            ST_START:    w_state_nxt = ST_PREAMBLE;
            ST_PREAMBLE: if (r_cnt == c_PRE_LAST) w_state_nxt = ST_SFD;
            ST_SFD:      w_state_nxt = ST_MACDST;
            ST_MACDST:   if (r_cnt == c_MAC_LAST) w_state_nxt = ST_MACSRC;
            ST_MACSRC:   if (r_cnt == c_MAC_LAST) w_state_nxt = ST_LEN;
            ST_LEN:      if (r_cnt == c_LEN_LAST)
                             w_state_nxt = (r_len == 16'd0) ? ST_FCS : ST_PAYLOAD;
            ST_PAYLOAD:  if (r_cnt == r_len - 16'd1) w_state_nxt = ST_FCS;
            ST_FCS:      if (r_cnt == c_FCS_LAST) w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase

        // A missing payload byte truncates the frame immediately.
        if (w_underrun) begin
            w_state_nxt = ST_IDLE;
        end

        if ((w_state_nxt != r_state) || (w_state_nxt == ST_IDLE)) begin
            w_cnt_nxt = 16'd0;
        end else begin
            w_cnt_nxt = r_cnt + 16'd1;
        end

        w_data_nxt = 8'h00;
        case (w_state_nxt)
            ST_PREAMBLE: w_data_nxt = PREAMBLE_BYTE;
            ST_SFD:      w_data_nxt = SFD_BYTE;
            ST_MACDST:   w_data_nxt = mac_byte(r_dst_mac, w_cnt_nxt[2:0]);
            ST_MACSRC:   w_data_nxt = mac_byte(SRC_MAC_ADDR, w_cnt_nxt[2:0]);
            ST_LEN:      w_data_nxt = (w_cnt_nxt == 16'd0) ? r_len[15:8] : r_len[7:0];
            ST_PAYLOAD:  w_data_nxt = bus.in_data;
            ST_FCS:      w_data_nxt = w_fcs_byte;
            default:     w_data_nxt = 8'h00;
        endcase

        w_lrc_en = (w_state_nxt == ST_MACDST) || (w_state_nxt == ST_MACSRC)
                   || (w_state_nxt == ST_LEN) || (w_state_nxt == ST_PAYLOAD);
    end

    // State, latched request fields and registered frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 16'd0;
            r_dst_mac  <= '0;
            r_len      <= 16'd0;
            r_start    <= 1'b0;
            r_data     <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_tx_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_start    <= (w_state_nxt == ST_START);
            r_data     <= w_data_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done     <= (w_state_nxt == ST_DONE);
            r_underrun <= w_underrun;
            r_tx_err   <= w_len_err;
            if (w_tx_ack) begin
                r_dst_mac <= bus.tx_dst_mac;
                r_len     <= bus.tx_len;
            end
        end
    end

    eth_lrc_acc u_lrc (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_tx_ack),
        .i_en       (w_lrc_en),
        .i_byte     (w_data_nxt),
        .o_sum      (w_lrc_sum),
        .o_fcs_byte (w_fcs_byte)
    );

    assign bus.tx_ack   = w_tx_ack;
    assign bus.tx_err   = r_tx_err;
    assign bus.in_rdy   = w_in_rdy;
    assign bus.start    = r_start;
    assign bus.data     = r_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.underrun = r_underrun;

endmodule
`default_nettype wire
